// File: rtl/pc_sequencer_if.sv
// Decode-side handshake bundle for the PC sequencer: instruction/condition inputs and fetch-side outputs.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              instr_valid;
    logic [1:0]        op;
    logic [7:0]        cond_sel;
    logic              cond_inv;
    logic [5:0]        cond_flags;
    logic [ADDR_W-1:0] target;
    logic              stall;

    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic              fault;

    modport master (
        output instr_valid, op, cond_sel, cond_inv, cond_flags, target, stall,
        input  pc, pc_valid, flush, fault
    );

    modport slave (
        input  instr_valid, op, cond_sel, cond_inv, cond_flags, target, stall,
        output pc, pc_valid, flush, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: condition evaluation, next-PC selection, redirect bubble and fault lock.
// Return-address stack (CALL/RET, fault) is built only when PC_SEQUENCER_CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [1:0] OP_NEXT = 2'd0;
    localparam logic [1:0] OP_JUMP = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    // REDIR is the flush cycle carrying the new pc; BUBBLE follows before fetch resumes.
    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_RUN    = 3'd1,
        ST_REDIR  = 3'd2,
        ST_BUBBLE = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              flush_q;
    logic              fault_q;

    logic              cond_true_c;
    logic              taken_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] npc_c;
    logic              redirect_c;
    logic              fault_hit_c;
    logic              decide_c;

    assign pc_inc_c = pc_q + ADDR_W'(1);
    assign decide_c = (state_q == ST_RUN) && bus.instr_valid && !bus.stall;

    always_comb begin : cond_eval
        cond_true_c = 1'b0;
        if (bus.cond_sel == 8'd1) begin
            cond_true_c = 1'b1;
        end else if ((bus.cond_sel >= 8'd2) && (bus.cond_sel <= 8'd7)) begin
            cond_true_c = bus.cond_flags[3'(bus.cond_sel - 8'd2)];
        end
        taken_c = cond_true_c ^ bus.cond_inv;
    end

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              stack_full_c;
    logic              stack_empty_c;
    logic [ADDR_W-1:0] stack_top_c;
    logic              push_c;
    logic              pop_c;

    assign stack_full_c  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty_c = (sp_q == '0);
    assign stack_top_c   = stack_q[IDX_W'(sp_q - SP_W'(1))];
`endif

    // Next-pc selection for a RUN-state decision; misuse of the stack keeps pc and faults.
    always_comb begin : next_pc
        npc_c       = pc_inc_c;
        redirect_c  = 1'b0;
        fault_hit_c = 1'b0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
        push_c      = 1'b0;
        pop_c       = 1'b0;
`endif
        if (decide_c && taken_c) begin
            unique case (bus.op)
                OP_NEXT: ;
                OP_JUMP: begin
                    redirect_c = 1'b1;
                    npc_c      = bus.target;
                end
                OP_CALL: begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
                    if (stack_full_c) begin
                        fault_hit_c = 1'b1;
                        npc_c       = pc_q;
                    end else begin
                        push_c     = 1'b1;
                        redirect_c = 1'b1;
                        npc_c      = bus.target;
                    end
`else
                    redirect_c = 1'b1;
                    npc_c      = bus.target;
`endif
                end
                OP_RET: begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
                    if (stack_empty_c) begin
                        fault_hit_c = 1'b1;
                        npc_c       = pc_q;
                    end else begin
                        pop_c      = 1'b1;
                        redirect_c = 1'b1;
                        npc_c      = stack_top_c;
                    end
`endif
                end
            endcase
        end
    end

    // Sequencer FSM with registered outputs; stall freezes everything and drops flush.
    always_ff @(posedge clk or negedge rst_n) begin : fsm
        if (!rst_n) begin
            state_q    <= ST_START;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (!bus.stall) begin
                unique case (state_q)
                    ST_START: begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                    ST_RUN: begin
                        if (bus.instr_valid) begin
                            pc_q <= npc_c;
                            if (fault_hit_c) begin
                                state_q    <= ST_FAULT;
                                pc_valid_q <= 1'b0;
                                flush_q    <= 1'b1;
                                fault_q    <= 1'b1;
                            end else if (redirect_c) begin
                                state_q    <= ST_REDIR;
                                pc_valid_q <= 1'b0;
                                flush_q    <= 1'b1;
                            end
                        end
                    end
                    ST_REDIR: begin
                        state_q <= ST_BUBBLE;
                    end
                    ST_BUBBLE: begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                    ST_FAULT: ;
                    default: begin
                        state_q    <= ST_START;
                        pc_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PC_SEQUENCER_CALL_STACK_EN
    // Return-address stack; sp_q counts occupied entries.
    always_ff @(posedge clk or negedge rst_n) begin : ras
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_c) begin
            stack_q[IDX_W'(sp_q)] <= pc_inc_c;
            sp_q                  <= sp_q + SP_W'(1);
        end else if (pop_c) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.flush    = flush_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam logic [7:0]  RST_PC = 8'h10;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    pc_sequencer #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (RST_PC),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pc, visible flags, cycles left before fetch is valid, and a return-address queue.
    logic [7:0] m_pc;
    logic       m_valid, m_flush, m_fault;
    int         m_blank;
    logic [7:0] ras[$];

    function automatic bit model_taken(logic [7:0] cs, logic ci, logic [5:0] cf);
        bit c = 1'b0;
        int idx;
        if (cs == 8'd1) c = 1'b1;
        else if (cs >= 8'd2 && cs <= 8'd7) begin
            idx = int'(cs) - 2;
            c = cf[idx];
        end
        return c ^ ci;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_valid = 0; m_flush = 0; m_fault = 0; m_blank = 1;
        ras.delete();
    endtask

    task automatic m_redirect(logic [7:0] t);
        m_pc = t; m_flush = 1; m_valid = 0; m_blank = 2;
    endtask

    task automatic m_trap();
        m_fault = 1; m_flush = 1; m_valid = 0;
    endtask

    task automatic model_step();
        logic [7:0] seq;
        m_flush = 0;
        if (bus.stall || m_fault) return;
        if (m_blank > 0) begin
            m_blank--;
            if (m_blank == 0) m_valid = 1;
            return;
        end
        if (!bus.instr_valid) return;
        seq = m_pc + 8'd1;
        if (bus.op == 2'd0 || !model_taken(bus.cond_sel, bus.cond_inv, bus.cond_flags)) begin
            m_pc = seq;
        end else if (bus.op == 2'd1) begin
            m_redirect(bus.target);
        end else if (bus.op == 2'd2) begin
            if (!HAS_STACK) m_redirect(bus.target);
            else if (ras.size() == DEPTH) m_trap();
            else begin ras.push_back(seq); m_redirect(bus.target); end
        end else begin
            if (!HAS_STACK) m_pc = seq;
            else if (ras.size() == 0) m_trap();
            else m_redirect(ras.pop_back());
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".pc"},       bus.pc,               m_pc);
        chk({tag, ".pc_valid"}, 8'(bus.pc_valid),     8'(m_valid));
        chk({tag, ".flush"},    8'(bus.flush),        8'(m_flush));
        chk({tag, ".fault"},    8'(bus.fault),        8'(m_fault));
    endtask

    task automatic drv(bit iv, bit [1:0] o, bit [7:0] cs, bit ci, bit [5:0] cf, bit [7:0] tg, bit st);
        bus.instr_valid = iv; bus.op = o; bus.cond_sel = cs; bus.cond_inv = ci;
        bus.cond_flags = cf; bus.target = tg; bus.stall = st;
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic ticks(string tag, int n);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset("reset");
        chk("reset_pc_const", bus.pc, 8'h10);

        // Start cycle then sequential fetch 10..13
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        tick("start");
        ticks("seq", 3);
        chk("seq_pc_13", bus.pc, 8'h13);

        // Taken jump on flag in4, then not taken, then inverted false
        drv(1, 2'd1, 8'd4, 0, 6'b000100, 8'h40, 0);
        tick("jmp_taken");
        chk("jmp_flush_pc", bus.pc, 8'h40);
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        ticks("jmp_bubble", 2);
        drv(1, 2'd1, 8'd4, 0, 6'b000000, 8'h50, 0);
        tick("jmp_not_taken");
        chk("jmp_nt_pc", bus.pc, 8'h41);
        drv(1, 2'd1, 8'd0, 1, 6'b000000, 8'h60, 0);
        ticks("jmp_inv", 3);
        chk("jmp_inv_pc", bus.pc, 8'h60);

        // Call at 20 to 80, walk to 85, return
        drv(1, 2'd1, 8'd1, 0, 0, 8'h20, 0);
        ticks("to20", 3);
        drv(1, 2'd2, 8'd1, 0, 0, 8'h80, 0);
        ticks("call", 3);
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        ticks("walk", 5);
        chk("at85", bus.pc, 8'h85);
        drv(1, 2'd3, 8'd1, 0, 0, 0, 0);
        ticks("ret", 3);
        if (HAS_STACK) chk("ret_pc_21", bus.pc, 8'h21);

        // Return with empty stack
        do_reset("rst2");
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        tick("start2");
        drv(1, 2'd3, 8'd1, 0, 0, 0, 0);
        ticks("ret_empty", 3);

        // Five nested calls against a depth-4 stack
        do_reset("rst3");
        tick("start3");
        for (int i = 0; i < 5; i++) begin
            drv(1, 2'd2, 8'd1, 0, 0, 8'h30 + 8'(i * 8), 0);
            ticks("nest", 3);
        end

        // Wrap at all-ones, and a call from FF returning to 00
        do_reset("rst4");
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        tick("start4");
        drv(1, 2'd1, 8'd1, 0, 0, 8'hFF, 0);
        ticks("toFF", 3);
        drv(1, 2'd0, 0, 0, 0, 0, 0);
        tick("wrap");
        chk("wrap_pc_00", bus.pc, 8'h00);
        drv(1, 2'd1, 8'd1, 0, 0, 8'hFF, 0);
        ticks("toFF2", 3);
        drv(1, 2'd2, 8'd1, 0, 0, 8'h30, 0);
        ticks("callFF", 3);
        drv(1, 2'd3, 8'd1, 0, 0, 0, 0);
        ticks("retFF", 3);
        if (HAS_STACK) chk("ret_wrap_00", bus.pc, 8'h00);

        // Stall held over a taken jump decision, then released
        drv(1, 2'd1, 8'd1, 0, 0, 8'h77, 1);
        ticks("stall", 3);
        drv(1, 2'd1, 8'd1, 0, 0, 8'h77, 0);
        ticks("stall_rel", 3);
        chk("stall_pc_77", bus.pc, 8'h77);

        // Async reset while in the bubble
        drv(1, 2'd1, 8'd1, 0, 0, 8'h9A, 0);
        ticks("to_bubble", 2);
        do_reset("rst_bubble");
        chk("rst_bubble_flush", 8'(bus.flush), 8'h00);

        // Randomized traffic
        drv(0, 0, 0, 0, 0, 0, 0);
        tick("rand_start");
        for (int n = 0; n < 600; n++) begin
            if (m_fault || $urandom_range(0, 79) == 0) do_reset("rand_rst");
            drv($urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom),
                1'($urandom_range(0, 1)),
                6'($urandom),
                8'($urandom),
                $urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor core. Sits between decode and instruction fetch. Evaluates the branch condition selected by the instruction's condition code against the ALU flag bits, using the same 8-bit encoding as the condition mux, then chooses the next PC: sequential, jump, call or return. Holds a small return-address stack, inserts a one-cycle bubble on every redirect, and locks into a fault state on stack misuse.

## Interface
- `ADDR_W`, 8, PC / target width in bits
- `RESET_PC`, 0, PC value loaded on reset
- `STACK_DEPTH`, 4, return-address stack entries (≥2, power of 2 not required)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  decode presents an instruction for the current `pc`
- `op`  in  2  0 NEXT, 1 JUMP, 2 CALL, 3 RET
- `cond_sel`  in  8  condition code: 0 false, 1 true, 2..7 select `cond_flags[0..5]`, 8..255 false
- `cond_inv`  in  1  invert evaluated condition
- `cond_flags`  in  6  flag inputs (in2..in7 order)
- `target`  in  ADDR_W  jump/call destination
- `stall`  in  1  downstream stall; freezes the sequencer
- `pc`  out  ADDR_W  current fetch address
- `pc_valid`  out  1  `pc` is a real fetch
- `flush`  out  1  one-cycle pulse; discard the in-flight instruction
- `fault`  out  1  stack overflow/underflow latched

## Operation
- Reset values: `pc`=RESET_PC, `pc_valid`=0, `flush`=0, `fault`=0, stack empty, state START.
- `taken` = cond(cond_sel) XOR cond_inv. `op`=NEXT ignores `taken`.
- States:
  - START: one cycle after reset release, `pc_valid`=0, then RUN.
  - RUN: `pc_valid`=1. A decision happens only when `instr_valid`=1 and `stall`=0. Decisions:
    - NEXT, or not taken: `pc` ← pc+1.
    - Taken JUMP: `pc` ← target.
    - Taken CALL: push pc+1, then `pc` ← target.
    - Taken RET: pop, then `pc` ← popped value.
    - Any taken redirect: `flush`=1 the next cycle, then BUBBLE.
  - BUBBLE: `pc_valid`=0, `instr_valid` ignored, one cycle only, then RUN. `stall` extends BUBBLE.
  - FAULT: `pc` held, `pc_valid`=0, `fault`=1. Exit only by reset.
- Taken CALL with the stack full: no push, `pc` unchanged, go to FAULT, `flush`=1.
- Taken RET with the stack empty: same behaviour as CALL-with-stack-full.
- PC arithmetic is modulo 2^ADDR_W; pc+1 at all-ones wraps to 0, and a pushed return address wraps the same way.
- `instr_valid`=0 in RUN: `pc` holds, no state change.
- `stall`=1 in any state: all registers hold, `flush` deasserts.
- Reset asserted mid-operation: all outputs and the stack return to reset values immediately (asynchronous).

## Timing
- Decision-to-new-`pc`: 1 cycle (registered).
- `flush` is high for exactly the cycle in which the redirected `pc` first appears.
- Redirect cost: the `pc` cycle plus one BUBBLE cycle, i.e. the target is fetched with `pc_valid`=1 two cycles after the decision.
- Sequential throughput: one `pc` per cycle.
- No combinational path from inputs to outputs.

## Configuration
- `PC_SEQUENCER_CALL_STACK_EN` defined: return-address stack present; CALL and RET behave as described above, and `fault` is reachable.
- `PC_SEQUENCER_CALL_STACK_EN` undefined: no stack storage. Taken CALL behaves as JUMP. Taken RET behaves as NEXT with no flush. `fault` is tied to 0 and FAULT is unreachable.

## Test plan
- Reset with RESET_PC=8'h10, release, then NEXT ×3 with `instr_valid`=1 → `pc_valid` low for 1 cycle, then `pc` = 10, 11, 12, 13.
- JUMP, cond_sel=4, cond_flags=6'b000100, target=8'h40 → next cycle `pc`=40 with `flush`=1; next cycle `pc_valid`=0; then `pc`=40 valid. Repeat with cond_flags=0 → `pc` increments, no flush. Repeat with cond_sel=0, cond_inv=1 → taken.
- CALL at pc=8'h20, cond_sel=1, target=8'h80; then RET at 8'h85 → `pc`=80, and later `pc`=21.
- 5 nested taken CALLs with STACK_DEPTH=4 → the 5th gives `fault`=1, `pc_valid`=0 and `pc` frozen. A RET with the stack empty after reset also gives `fault`=1.
- `pc`=8'hFF, NEXT → `pc`=00. CALL at 8'hFF then RET → return to 00.
- `stall`=1 held 3 cycles during a taken JUMP decision, then released → `pc` unchanged during the stall, then redirect proceeds. `rst_n` pulsed low in BUBBLE → immediate `pc`=RESET_PC, `flush`=0.
